// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a holding register, start/load strobes and done pulse.
// Ports: clk, reset (sync, active-high), data_in[7:0], tx_load, tx_start -> tx, busy, tx_done.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       tx_load,
  input  logic       tx_start,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        last;

  assign last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = last ? 16'd0 : baud_q + 16'd1;
    bit_d   = bit_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        bit_d  = 3'd0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_load && !busy_q) begin
          hold_d = data_in;
        end
        // The done cycle blocks a restart so every frame
        // is followed by at least one observable idle cycle.
        if (tx_start && !done_q) begin
          shift_d = tx_load ? data_in : hold_q;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (last) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      STOP: begin
        if (last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      hold_q  <= 8'h00;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4 with an expected-byte scoreboard.
// Frames are sampled at bit centres and compared against queued bytes.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_start = 1'b0;
  logic       tx, busy, tx_done;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] hold_m = 8'h00;

  uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .tx_load(tx_load),
    .tx_start(tx_start),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_only(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    tx_load = 1'b1;
    hold_m  = b;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Call right after a negedge; the next posedge starts the frame.
  task automatic kick(input logic ld, input logic [7:0] b);
    if (ld) begin
      data_in = b;
      tx_load = 1'b1;
      hold_m  = b;
    end
    tx_start = 1'b1;
    exp_q.push_back(hold_m);
  endtask

  task automatic run_frame(input string tag, input int inject_at,
                           input int abort_at);
    logic [9:0] frm;
    logic [7:0] e;
    int bc, dc;
    frm = '0;
    bc = 0;
    dc = 0;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tx_start = 1'b0;
      tx_load  = 1'b0;
      if (i == inject_at) begin
        data_in  = 8'hFF;
        tx_load  = 1'b1;
        tx_start = 1'b1;
      end
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk({tag, "_abort_tx"}, 32'(tx), 32'd1);
        chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
        chk({tag, "_abort_done"}, 32'(tx_done), 32'd0);
        hold_m = 8'h00;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        return;
      end
      if (busy) bc++;
      if (tx_done) dc++;
      if (i % 4 == 2) frm[i/4] = tx;
    end
    @(negedge clk);
    tx_start = 1'b0;
    tx_load  = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd40);
    chk({tag, "_done_early"}, 32'(dc), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulse"}, 32'(tx_done), 32'd1);
    chk({tag, "_tx_idle"}, 32'(tx), 32'd1);
    chk({tag, "_q_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    chk({tag, "_frame"}, 32'(frm), 32'({1'b1, e, 1'b0}));
  endtask

  initial begin
    int act;
    logic [7:0] r;

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    kick(1'b0, 8'h00);
    run_frame("no_load_zero", -1, -1);

    load_only(8'hA5);
    kick(1'b0, 8'h00);
    run_frame("a5", -1, -1);
    @(negedge clk);

    @(negedge clk);
    kick(1'b1, 8'h3C);
    run_frame("bypass_3c", -1, -1);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("start_in_done_busy", 32'(busy), 32'd0);
    chk("start_in_done_tx", 32'(tx), 32'd1);
    kick(1'b0, 8'h00);
    run_frame("b2b_hold_3c", -1, -1);

    @(negedge clk);
    @(negedge clk);
    kick(1'b1, 8'h55);
    run_frame("ignore_55", 12, -1);
    @(negedge clk);
    @(negedge clk);
    kick(1'b0, 8'h00);
    run_frame("resend_55", -1, -1);

    @(negedge clk);
    @(negedge clk);
    kick(1'b1, 8'h9A);
    run_frame("abort", -1, 17);
    reset = 1'b0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!tx || busy || tx_done) act++;
    end
    chk("abort_quiet", 32'(act), 32'd0);

    @(negedge clk);
    kick(1'b0, 8'h00);
    run_frame("after_abort_zero", -1, -1);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      @(negedge clk);
      r = 8'($urandom_range(0, 255));
      kick(1'b1, r);
      run_frame("rand", -1, -1);
    end

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
